// File: rtl/pulse_int_framer_pkg.sv
// Shared definitions for the pulse integrator output framer.
//
// Contents:
//   HEADER_MAGIC    magic byte carried in the top byte of every header word
//   HDR_*           bit positions of the header word fields
//   state_t         framer FSM state encoding (CSUM is only reachable when
//                   PULSE_INT_FRAMER_CHECKSUM_EN is defined)
//   header_word()   builds the 32-bit header word from a frame count
`timescale 1ns/1ps
package pulse_int_framer_pkg;

    localparam logic [7:0] HEADER_MAGIC  = 8'hA5;
    localparam int         HDR_W         = 32;
    localparam int         HDR_COUNT_LSB = 0;
    localparam int         HDR_COUNT_W   = 16;
    localparam int         HDR_RSVD_LSB  = 16;
    localparam int         HDR_MAGIC_LSB = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        CSUM   = 2'd3
    } state_t;

    // Header layout: [31:24] magic, [23:16] reserved (zero), [15:0] frame count.
    function automatic logic [HDR_W-1:0] header_word(input logic [HDR_COUNT_W-1:0] count);
        logic [HDR_W-1:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 8]           = HEADER_MAGIC;
        w[HDR_COUNT_LSB +: HDR_COUNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/pulse_int_framer_fifo.sv
// Synchronous first-word-fall-through FIFO.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset (empties the FIFO)
//   push, din     write request and data; ignored while full
//   pop           read request; ignored while empty
//   dout          head of the FIFO, valid whenever empty is low
//   full, empty   occupancy flags
//
// Push and pop in the same cycle (non-full, non-empty) leave occupancy unchanged.
`timescale 1ns/1ps
module pulse_int_framer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pulse_int_framer.sv
// Pulse integrator output framer: normalises incoming integrated samples by a
// power-of-two shift, buffers them, and emits AXI-Stream frames of one header
// word followed by len data words (tlast on the final word).
//
// Optional feature macro: PULSE_INT_FRAMER_CHECKSUM_EN appends an XOR trailer
// word (carrying tlast) after the data words of each frame.
//
// Handshake: a word moves on a rising aclk edge where tvalid and tready are
// both high. A source never waits for ready before raising valid, and once
// valid is raised its data/last stay unchanged until the transfer happens.
//
// Ports:
//   aclk, areset     clock, asynchronous active-high reset
//   s_axis_*         sample input (tready = FIFO not full)
//   m_axis_*         framed output stream (registered)
//   win_len          data words per frame, 0 treated as 1; latched per frame
//   scale_shift      logical right shift applied at the accept edge
//   frame_count      frames completed since reset (wraps)
//   overflow         sticky: a sample arrived while the FIFO was full
//   fsm_state        current framer state, for observation
`timescale 1ns/1ps
module pulse_int_framer
    import pulse_int_framer_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    input  logic [15:0]                win_len,
    input  logic [4:0]                 scale_shift,
    output logic [15:0]                frame_count,
    output logic                       overflow,
    output state_t                     fsm_state
);

    localparam int W = AXIS_DATA_WIDTH;

    state_t       state, state_d;
    logic         tvalid_q, tvalid_d;
    logic         tlast_q, tlast_d;
    logic [W-1:0] tdata_q, tdata_d;
    logic [15:0]  len_q, len_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  fc_q, fc_d;
    logic         overflow_q;
    logic         fifo_full, fifo_empty;
    logic [W-1:0] fifo_dout;
    logic [W-1:0] norm;
    logic         push, pop, load_data, hs, last_word;
`ifdef PULSE_INT_FRAMER_CHECKSUM_EN
    logic [W-1:0] csum_q, csum_d;
`endif

    assign norm      = s_axis_tdata >> scale_shift;
    assign push      = s_axis_tvalid & ~fifo_full;
    assign hs        = tvalid_q & m_axis_tready;
    assign last_word = (cnt_q == len_q - 16'd1);

    pulse_int_framer_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (push),
        .din   (norm),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The output register is loaded straight from the FIFO head, so a data
    // word leaves the FIFO when it enters the register rather than when it is
    // accepted downstream. cnt is the index of the data word in the register.
    always_comb begin
        state_d   = state;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        fc_d      = fc_q;
        load_data = 1'b0;
`ifdef PULSE_INT_FRAMER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty && !tvalid_q) begin
                    state_d  = HEADER;
                    len_d    = (win_len == 16'd0) ? 16'd1 : win_len;
                    tvalid_d = 1'b1;
                    tdata_d  = W'(header_word(fc_q));
                    tlast_d  = 1'b0;
`ifdef PULSE_INT_FRAMER_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            HEADER: begin
                if (hs) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    tvalid_d  = 1'b0;
                    load_data = !fifo_empty;
                end
            end
            DATA: begin
                if (hs) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (last_word) begin
`ifdef PULSE_INT_FRAMER_CHECKSUM_EN
                        state_d  = CSUM;
                        tvalid_d = 1'b1;
                        tdata_d  = csum_q;
                        tlast_d  = 1'b1;
`else
                        state_d  = IDLE;
                        fc_d     = fc_q + 16'd1;
`endif
                    end else begin
                        cnt_d     = cnt_q + 16'd1;
                        load_data = !fifo_empty;
                    end
                end else if (!tvalid_q) begin
                    // Stalled on an empty FIFO mid-frame; resume when data arrives.
                    load_data = !fifo_empty;
                end
            end
            CSUM: begin
                if (hs) begin
                    state_d  = IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    fc_d     = fc_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_data) begin
            tvalid_d = 1'b1;
            tdata_d  = fifo_dout;
`ifdef PULSE_INT_FRAMER_CHECKSUM_EN
            tlast_d  = 1'b0;
            csum_d   = csum_q ^ fifo_dout;
`else
            tlast_d  = (cnt_d == len_q - 16'd1);
`endif
        end
    end

    assign pop = load_data;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            len_q      <= 16'd1;
            cnt_q      <= '0;
            fc_q       <= '0;
            overflow_q <= 1'b0;
`ifdef PULSE_INT_FRAMER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state      <= state_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            fc_q       <= fc_d;
            overflow_q <= overflow_q | (s_axis_tvalid & fifo_full);
`ifdef PULSE_INT_FRAMER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign s_axis_tready = ~fifo_full;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_count   = fc_q;
    assign overflow      = overflow_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_pulse_int_framer.sv
// Self-checking bench for pulse_int_framer (AXIS_DATA_WIDTH=32, FIFO_DEPTH=16).
`timescale 1ns/1ps
module tb_pulse_int_framer;
    import pulse_int_framer_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [15:0] win_len;
    logic [4:0]  scale_shift;
    logic [15:0] frame_count;
    logic        overflow;
    state_t      fsm_state;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 held low
    int          hs_count = 0;

    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    logic [31:0] frame_buf[$];
    logic [15:0] exp_frames = 16'd0;

    logic        held_prev = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    typedef struct {
        logic [31:0] din;
        logic [4:0]  sh;
        logic [31:0] dout;
    } vec_t;
    vec_t vecs[7];

    pulse_int_framer #(
        .AXIS_DATA_WIDTH (32),
        .FIFO_DEPTH      (16)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .win_len       (win_len),
        .scale_shift   (scale_shift),
        .frame_count   (frame_count),
        .overflow      (overflow),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference framing: header with the model frame count, the buffered data
    // words, tlast on the final word of the frame (trailer when enabled).
    task automatic push_frame();
        logic [31:0] x;
        x = 32'h0;
        exp_q.push_back({8'hA5, 8'h00, exp_frames});
        exp_last_q.push_back(1'b0);
        for (int i = 0; i < frame_buf.size(); i++) begin
            x ^= frame_buf[i];
            exp_q.push_back(frame_buf[i]);
`ifdef PULSE_INT_FRAMER_CHECKSUM_EN
            exp_last_q.push_back(1'b0);
`else
            exp_last_q.push_back(i == frame_buf.size() - 1);
`endif
        end
`ifdef PULSE_INT_FRAMER_CHECKSUM_EN
        exp_q.push_back(x);
        exp_last_q.push_back(1'b1);
`endif
        exp_frames = exp_frames + 16'd1;
        frame_buf.delete();
    endtask

    // Output monitor / scoreboard, sampled mid-cycle.
    always @(negedge aclk) begin
        if (areset) begin
            held_prev = 1'b0;
        end else begin
            if (held_prev) begin
                check("hold_valid", 32'(m_axis_tvalid), 32'd1);
                check("hold_data", m_axis_tdata, held_data);
                check("hold_last", 32'(m_axis_tlast), 32'(held_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %h, expected no word (t=%0t)", m_axis_tdata, $time);
                end else begin
                    check("word", m_axis_tdata, exp_q.pop_front());
                    check("tlast", 32'(m_axis_tlast), 32'(exp_last_q.pop_front()));
                end
            end
            held_prev = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            held_last = m_axis_tlast;
        end
    end

    // ---------------- drivers ----------------
    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = !m_axis_tready;
            2:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Called just after a rising edge; presents one sample for one edge.
    task automatic send_sample(input logic [31:0] d, input logic [4:0] sh);
        s_axis_tdata  = d;
        scale_shift   = sh;
        s_axis_tvalid = 1'b1;
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
            @(posedge aclk); #1;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        repeat (3) begin @(posedge aclk); #1; end
        check({name, "_frames"}, 32'(frame_count), 32'(exp_frames));
    endtask

    // ---------------- stimulus ----------------
    int          len, eff, nfr, base;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [31:0] ds[$];
    logic [4:0]  ss[$];

    initial begin
        vecs[0] = '{32'h0000_0010, 5'd2,  32'h0000_0004};
        vecs[1] = '{32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[2] = '{32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF};
        vecs[3] = '{32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[4] = '{32'h1234_5678, 5'd16, 32'h0000_1234};
        vecs[5] = '{32'h0000_0007, 5'd3,  32'h0000_0000};
        vecs[6] = '{32'hDEAD_BEEF, 5'd8,  32'h00DE_ADBE};

        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'h0;
        win_len       = 16'd4;
        scale_shift   = 5'd0;
        repeat (3) @(posedge aclk); #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'h0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd1);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        areset = 1'b0;
        @(posedge aclk); #1;

        // Basic frame: header A5000000 then 4, 8, 12, 16 with tlast on 16.
        rdy_mode = 0;
        win_len  = 16'd4;
        frame_buf.push_back(32'd4);  frame_buf.push_back(32'd8);
        frame_buf.push_back(32'd12); frame_buf.push_back(32'd16);
        push_frame();
        send_sample(32'd16, 5'd2); send_sample(32'd32, 5'd2);
        send_sample(32'd48, 5'd2); send_sample(32'd64, 5'd2);
        drain("basic");

        // Same stimulus under a toggling tready.
        rdy_mode = 1;
        frame_buf.push_back(32'd4);  frame_buf.push_back(32'd8);
        frame_buf.push_back(32'd12); frame_buf.push_back(32'd16);
        push_frame();
        send_sample(32'd16, 5'd2); send_sample(32'd32, 5'd2);
        send_sample(32'd48, 5'd2); send_sample(32'd64, 5'd2);
        drain("toggle");

        // Normalisation table, one data word per frame.
        rdy_mode = 0;
        win_len  = 16'd1;
        for (int i = 0; i < 7; i++) begin
            frame_buf.push_back(vecs[i].dout);
            push_frame();
            send_sample(vecs[i].din, vecs[i].sh);
        end
        drain("table");

        // Randomised bursts against the reference model; never enough to fill.
        rdy_mode = 2;
        for (int b = 0; b < 20; b++) begin
            len = int'($urandom_range(0, 5));
            eff = (len == 0) ? 1 : len;
            nfr = int'($urandom_range(1, 15 / eff));
            if (nfr > 3) nfr = 3;
            win_len = 16'(len);
            ds.delete(); ss.delete();
            for (int f = 0; f < nfr; f++) begin
                for (int j = 0; j < eff; j++) begin
                    d  = $urandom;
                    sh = 5'($urandom_range(0, 31));
                    ds.push_back(d);
                    ss.push_back(sh);
                    frame_buf.push_back(d >> sh);
                end
                push_frame();
            end
            for (int i = 0; i < ds.size(); i++) begin
                send_sample(ds[i], ss[i]);
                repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            end
            drain("rand");
        end

        // Overflow: 20 samples into a 16-deep FIFO with the output stalled.
        rdy_mode = 3;
        repeat (2) begin @(posedge aclk); #1; end
        check("ovf_before", 32'(overflow), 32'd0);
        win_len = 16'd4;
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 4; j++) frame_buf.push_back(32'(100 + f * 4 + j));
            push_frame();
        end
        for (int i = 0; i < 20; i++) begin
            send_sample(32'(100 + i), 5'd0);
            check("ovf_s_tready", 32'(s_axis_tready), 32'(i < 15));
        end
        check("ovf_set", 32'(overflow), 32'd1);
        rdy_mode = 0;
        drain("ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset after the second data word of an 8-word frame.
        rdy_mode = 3;
        repeat (2) begin @(posedge aclk); #1; end
        win_len = 16'd8;
        for (int j = 0; j < 8; j++) frame_buf.push_back(32'(j + 1));
        push_frame();
        for (int j = 0; j < 8; j++) send_sample(32'(j + 1), 5'd0);
        base     = hs_count;
        rdy_mode = 0;
        for (int i = 0; i < 100 && hs_count < base + 3; i++) begin
            @(posedge aclk); #1;
        end
        check("rst_mid_reached", 32'(hs_count >= base + 3), 32'd1);
        areset = 1'b1;
        #1;
        check("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_mid_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_mid_tdata", m_axis_tdata, 32'h0);
        check("rst_mid_frame_count", 32'(frame_count), 32'd0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        check("rst_mid_s_tready", 32'(s_axis_tready), 32'd1);
        check("rst_mid_state", 32'(fsm_state), 32'(IDLE));
        exp_q.delete();
        exp_last_q.delete();
        frame_buf.delete();
        exp_frames = 16'd0;
        @(posedge aclk);
        @(negedge aclk);
        areset   = 1'b0;
        rdy_mode = 3;
        repeat (2) begin @(posedge aclk); #1; end

        // win_len=0: three one-word frames, header counts 0,1,2; latency check
        // on the first, plus a mid-frame win_len change that must be ignored.
        win_len = 16'd0;
        for (int k = 0; k < 3; k++) begin
            frame_buf.push_back(32'(5 + k));
            push_frame();
        end
        send_sample(32'd5, 5'd0);
        check("lat_accept_edge", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk); #1;
        check("lat_hdr_valid", 32'(m_axis_tvalid), 32'd1);
        check("lat_hdr_data", m_axis_tdata, 32'hA500_0000);
        win_len  = 16'd9;
        rdy_mode = 0;
        @(posedge aclk); #2;
        check("lat_hdr_held", m_axis_tdata, 32'hA500_0000);
        @(posedge aclk); #1;
        check("lat_data_valid", 32'(m_axis_tvalid), 32'd1);
        check("lat_data", m_axis_tdata, 32'd5);
`ifdef PULSE_INT_FRAMER_CHECKSUM_EN
        check("lat_data_last", 32'(m_axis_tlast), 32'd0);
`else
        check("lat_data_last", 32'(m_axis_tlast), 32'd1);
`endif
        win_len = 16'd0;
        send_sample(32'd6, 5'd0);
        send_sample(32'd7, 5'd0);
        drain("wl0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
